// File: rtl/fire2_squeeze_buffer_if.sv
// Bundle of signals between the fire2 squeeze layer, this buffer and the fire2 expand stage.
// Handshake: the squeeze side has no backpressure. The fire2_squeeze_sample pulse means ofm_in is valid this cycle.
// expand_en is the consumer's accept, and each high cycle in STREAM consumes one element.
// pix_valid marks the matching pix_out exactly one cycle later.
interface fire2_squeeze_buffer_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 16
);
    logic             fire2_squeeze_sample;
    logic             fire2_squeeze_finish;
    logic [WIDTH-1:0] ofm_in [0:DSP_NO-1];
    logic             expand_en;
    logic             ram_feedback;
    logic [WIDTH-1:0] pix_out;
    logic             pix_valid;
    logic             buffer_done;

    modport master (
        output fire2_squeeze_sample, fire2_squeeze_finish, ofm_in, expand_en,
        input  ram_feedback, pix_out, pix_valid, buffer_done
    );

    modport slave (
        input  fire2_squeeze_sample, fire2_squeeze_finish, ofm_in, expand_en,
        output ram_feedback, pix_out, pix_valid, buffer_done
    );
endinterface

// File: rtl/fire2_squeeze_buffer.sv
// Captures the fire2 squeeze feature map into RAM.
// It then replays the map as a zero-padded KxK im2col stream for the expand stage.
module fire2_squeeze_buffer #(
    parameter int WIDTH      = 16,
    parameter int DSP_NO     = 16,
    parameter int WOUT       = 64,
    parameter int KERNEL_DIM = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fire2_squeeze_buffer_if.slave bus,
    output logic [1:0]            state_dbg
);
    localparam int DEPTH = WOUT * WOUT;
    localparam int PAD   = (KERNEL_DIM - 1) / 2;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int RA    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = (WOUT > 1) ? $clog2(WOUT) : 1;
    localparam int KW    = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
    localparam int CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int SW    = ((PW > KW) ? PW : KW) + 2;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(WOUT - 1);
    localparam logic [KW-1:0] LAST_K  = KW'(KERNEL_DIM - 1);
    localparam logic [CW-1:0] LAST_C  = CW'(DSP_NO - 1);
    localparam logic [SW-1:0] PAD_S   = SW'(PAD);
    localparam logic [SW-1:0] HI_S    = SW'(WOUT + PAD);
    localparam logic [RA-1:0] WOUT_A  = RA'(WOUT);

    typedef enum logic [1:0] {FILL = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

    state_t                    state;
    logic [AW-1:0]             wr_addr;
    logic [PW-1:0]             row, col;
    logic [KW-1:0]             ky, kx;
    logic [CW-1:0]             ch;
    logic                      valid_q, pad_q;
    logic [CW-1:0]             ch_q;
    logic [DSP_NO*WIDTH-1:0]   mem [0:DEPTH-1];
    logic [DSP_NO*WIDTH-1:0]   wr_word, rd_word;
    logic [WIDTH-1:0]          rd_ch;
    logic [SW-1:0]             sum_r, sum_c, src_r, src_c;
    logic [RA-1:0]             rd_addr;
    logic                      pad, we, accept, last_elem;

    assign we        = (state == FILL) && bus.fire2_squeeze_sample && (wr_addr != DEPTH_A);
    assign accept    = (state == STREAM) && bus.expand_en;
    assign last_elem = (row == LAST_P) && (col == LAST_P) && (ky == LAST_K) &&
                       (kx == LAST_K) && (ch == LAST_C);

    // Window tap (row+ky-PAD, col+kx-PAD), computed offset by PAD so it never goes negative.
    assign sum_r   = SW'(row) + SW'(ky);
    assign sum_c   = SW'(col) + SW'(kx);
    assign pad     = (sum_r < PAD_S) || (sum_r >= HI_S) || (sum_c < PAD_S) || (sum_c >= HI_S);
    assign src_r   = sum_r - PAD_S;
    assign src_c   = sum_c - PAD_S;
    assign rd_addr = pad ? '0 : (RA'(src_r) * WOUT_A + RA'(src_c));

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < DSP_NO; i++) wr_word[i*WIDTH +: WIDTH] = bus.ofm_in[i];
    end

    always_comb begin
        rd_ch = '0;
        for (int i = 0; i < DSP_NO; i++)
            if (ch_q == CW'(i)) rd_ch = rd_word[i*WIDTH +: WIDTH];
    end

    // RAM is not reset. rd_word only moves on an accepted element, so pix_out holds during gaps.
    always_ff @(posedge clk) begin
        if (we)     mem[wr_addr[RA-1:0]] <= wr_word;
        if (accept) rd_word <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= FILL;
            wr_addr          <= '0;
            row              <= '0;
            col              <= '0;
            ky               <= '0;
            kx               <= '0;
            ch               <= '0;
            bus.ram_feedback <= 1'b0;
            bus.buffer_done  <= 1'b0;
            valid_q          <= 1'b0;
            pad_q            <= 1'b1;
            ch_q             <= '0;
        end else begin
            bus.ram_feedback <= 1'b0;
            valid_q          <= 1'b0;
            case (state)
                FILL: begin
                    if (we) wr_addr <= wr_addr + AW'(1);
                    // Full is judged on the registered address, so a same-cycle last write lands first.
                    if ((wr_addr == DEPTH_A) && bus.fire2_squeeze_finish) begin
                        state            <= STREAM;
                        bus.ram_feedback <= 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.expand_en) begin
                        valid_q <= 1'b1;
                        pad_q   <= pad;
                        ch_q    <= ch;
                        if (ch == LAST_C) begin
                            ch <= '0;
                            if (kx == LAST_K) begin
                                kx <= '0;
                                if (ky == LAST_K) begin
                                    ky <= '0;
                                    if (col == LAST_P) begin
                                        col <= '0;
                                        row <= (row == LAST_P) ? '0 : row + PW'(1);
                                    end else begin
                                        col <= col + PW'(1);
                                    end
                                end else begin
                                    ky <= ky + KW'(1);
                                end
                            end else begin
                                kx <= kx + KW'(1);
                            end
                        end else begin
                            ch <= ch + CW'(1);
                        end
                        if (last_elem) begin
                            state           <= DONE;
                            bus.buffer_done <= 1'b1;
                        end
                    end
                end
                DONE:    ;
                default: state <= FILL;
            endcase
        end
    end

    assign bus.pix_valid = valid_q;
    assign bus.pix_out   = pad_q ? '0 : rd_ch;
    assign state_dbg     = state;
endmodule
